// File: rtl/i2c_master.sv
// Single-byte I2C bus master: START, 7-bit address + R/W, ACK, one data byte, ACK/NACK, STOP.
// SCL is derived from clk; each bit period is four quarter-phases of CLK_DIV cycles.
module i2c_master #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [6:0]            slave_addr,
  input  logic                  rw,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  ack_err,
  output logic                  SCL_O,
  output logic                  SDA_O,
  input  logic                  SDA_I
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_RD_DATA, S_DATA_ACK, S_STOP
  } state_e;

  state_e                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [1:0]            phase_q, phase_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rshift_q, rshift_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rw_q, rw_d;
  logic                  ack_err_q, ack_err_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  scl_q, scl_d;
  logic                  sda_q, sda_d;
  logic                  tick_c, rise_c, period_end_c;

  // Registered state; reset releases the bus without generating STOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      phase_q   <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      wdata_q   <= '0;
      rshift_q  <= '0;
      rd_data_q <= '0;
      rw_q      <= 1'b0;
      ack_err_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      wdata_q   <= wdata_d;
      rshift_q  <= rshift_d;
      rd_data_q <= rd_data_d;
      rw_q      <= rw_d;
      ack_err_q <= ack_err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      scl_q     <= scl_d;
      sda_q     <= sda_d;
    end
  end

  assign tick_c       = (div_q == DIV_W'(CLK_DIV - 1));
  assign rise_c       = tick_c && (phase_q == 2'd1);
  assign period_end_c = tick_c && (phase_q == 2'd3);

  // Next-state logic; bus lines are registered from the next state and phase.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    wdata_d   = wdata_q;
    rshift_d  = rshift_q;
    rd_data_d = rd_data_q;
    rw_d      = rw_q;
    ack_err_d = ack_err_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    scl_d     = 1'b1;
    sda_d     = 1'b1;

    if (state_q != S_IDLE) begin
      div_d = tick_c ? '0 : div_q + DIV_W'(1);
      if (tick_c) phase_d = phase_q + 2'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_START;
          shift_d   = {slave_addr, rw};
          wdata_d   = wr_data;
          rw_d      = rw;
          ack_err_d = 1'b0;
          busy_d    = 1'b1;
          div_d     = '0;
          phase_d   = '0;
        end
      end
      S_START: begin
        if (period_end_c) begin
          state_d = S_ADDR;
          bit_d   = BIT_W'(7);
        end
      end
      S_ADDR: begin
        if (period_end_c) begin
          shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
          if (bit_q == '0) state_d = S_ADDR_ACK;
          else             bit_d   = bit_q - BIT_W'(1);
        end
      end
      S_ADDR_ACK: begin
        if (rise_c && SDA_I) ack_err_d = 1'b1;
        if (period_end_c) begin
          bit_d = BIT_W'(7);
          if (ack_err_q) begin
            state_d = S_STOP;
          end else if (rw_q) begin
            state_d = S_RD_DATA;
          end else begin
            state_d = S_WR_DATA;
            shift_d = wdata_q;
          end
        end
      end
      S_WR_DATA: begin
        if (period_end_c) begin
          shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
          if (bit_q == '0) state_d = S_DATA_ACK;
          else             bit_d   = bit_q - BIT_W'(1);
        end
      end
      S_RD_DATA: begin
        if (rise_c) rshift_d = {rshift_q[DATA_WIDTH-2:0], SDA_I};
        if (period_end_c) begin
          if (bit_q == '0) begin
            state_d   = S_DATA_ACK;
            rd_data_d = rshift_q;
          end else begin
            bit_d = bit_q - BIT_W'(1);
          end
        end
      end
      S_DATA_ACK: begin
        // After a read the master NACKs by leaving SDA released.
        if (rise_c && !rw_q && SDA_I) ack_err_d = 1'b1;
        if (period_end_c) state_d = S_STOP;
      end
      S_STOP: begin
        if (period_end_c) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_IDLE:               begin scl_d = 1'b1;       sda_d = 1'b1;                end
      S_START:              begin scl_d = 1'b1;       sda_d = ~phase_d[1];         end
      S_ADDR, S_WR_DATA:    begin scl_d = phase_d[1]; sda_d = shift_d[DATA_WIDTH-1]; end
      S_STOP:               begin scl_d = phase_d[1]; sda_d = (phase_d == 2'd3);   end
      default:              begin scl_d = phase_d[1]; sda_d = 1'b1;                end
    endcase
  end

  assign rd_data = rd_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign SCL_O   = scl_q;
  assign SDA_O   = sda_q;

endmodule

// File: tb/tb_i2c_master.sv
// Self-checking bench for i2c_master: a bit-period-level slave responder and
// a frame model (expected bus bits, latency, ack_err, rd_data) built from the bus rules.
module tb_i2c_master;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned BITP    = 4 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [6:0] slave_addr;
  logic       rw;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       busy, done, ack_err;
  logic       SCL_O, SDA_O, SDA_I;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_rd = 8'h00;

  i2c_master #(.CLK_DIV(CLK_DIV), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .slave_addr(slave_addr), .rw(rw),
    .wr_data(wr_data), .rd_data(rd_data), .busy(busy), .done(done),
    .ack_err(ack_err), .SCL_O(SCL_O), .SDA_O(SDA_O), .SDA_I(SDA_I)
  );

  always #5 clk = ~clk;

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Runs one frame; the responder drives SDA_I per bit period (0=START, 1-8 ADDR,
  // 9 ACK, 10-17 data, 18 data ACK). glitch_n pulses a conflicting start,
  // abort_n asserts rst in that cycle instead of letting the frame finish.
  task automatic run_frame(input string name, input logic [6:0] addr, input logic rw_in,
                           input logic [7:0] wdat, input logic addr_ack, input logic data_ack,
                           input logic [7:0] rbyte, input int glitch_n, input int abort_n);
    bit         exp_bits[$];
    bit         got_bits[$];
    logic [31:0] ev, gv;
    int         n, exp_n, period, starts, stops, busy_bad;
    logic       pscl, psda, seen_done, exp_err;

    for (int i = 6; i >= 0; i--) exp_bits.push_back(addr[i]);
    exp_bits.push_back(rw_in);
    exp_bits.push_back(1'b1);
    if (addr_ack) begin
      for (int i = 7; i >= 0; i--) exp_bits.push_back(rw_in ? 1'b1 : wdat[i]);
      exp_bits.push_back(1'b1);
    end
    exp_bits.push_back(1'b0);
    exp_n   = (addr_ack ? 20 : 11) * BITP + 1;
    exp_err = !addr_ack || (!rw_in && !data_ack);

    @(negedge clk);
    slave_addr = addr; rw = rw_in; wr_data = wdat; start = 1'b1; SDA_I = 1'b1;
    pscl = SCL_O; psda = SDA_O;
    n = 0; starts = 0; stops = 0; busy_bad = 0; seen_done = 1'b0;

    while (!seen_done && n < exp_n + 200) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (n == glitch_n) begin
        start = 1'b1; slave_addr = ~addr; rw = ~rw_in; wr_data = ~wdat;
      end
      if (n == abort_n) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (SCL_O !== 1'b1 || SDA_O !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
            rd_data !== 8'h00) begin
          errors++;
          $display("FAIL %s reset_mid_frame: scl=%b sda=%b busy=%b done=%b rd=%h, want 1 1 0 0 00",
                   name, SCL_O, SDA_O, busy, done, rd_data);
        end
        exp_rd = 8'h00;
        SDA_I  = 1'b1;
        return;
      end
      if (pscl === 1'b0 && SCL_O === 1'b1) got_bits.push_back(SDA_O);
      if (pscl === 1'b1 && SCL_O === 1'b1 && psda === 1'b1 && SDA_O === 1'b0) starts++;
      if (pscl === 1'b1 && SCL_O === 1'b1 && psda === 1'b0 && SDA_O === 1'b1) stops++;
      pscl = SCL_O; psda = SDA_O;
      if (n == 1) begin
        checks++;
        if (ack_err !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL %s accept: ack_err=%b busy=%b, want 0 1", name, ack_err, busy);
        end
      end
      if (done === 1'b1) seen_done = 1'b1;
      else if (busy !== 1'b1) busy_bad++;
      period = (n - 1) / BITP;
      SDA_I = 1'b1;
      if (addr_ack && period == 9) SDA_I = 1'b0;
      else if (addr_ack && rw_in && period >= 10 && period <= 17) SDA_I = rbyte[17 - period];
      else if (addr_ack && !rw_in && data_ack && period == 18) SDA_I = 1'b0;
    end
    SDA_I = 1'b1;

    checks++;
    if (!seen_done || n != exp_n) begin
      errors++;
      $display("FAIL %s latency: done_seen=%b at %0d cycles, want done at %0d", name, seen_done, n, exp_n);
    end
    if (rw_in && addr_ack) exp_rd = rbyte;
    checks++;
    if (ack_err !== exp_err || rd_data !== exp_rd || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s result: ack_err=%b rd=%h busy=%b, want %b %h 0",
               name, ack_err, rd_data, busy, exp_err, exp_rd);
    end
    ev = '0; gv = '0;
    foreach (exp_bits[i]) ev = {ev[30:0], exp_bits[i]};
    foreach (got_bits[i]) gv = {gv[30:0], got_bits[i]};
    checks++;
    if (got_bits.size() != exp_bits.size() || gv !== ev) begin
      errors++;
      $display("FAIL %s bus_bits: got %0d bits %h, want %0d bits %h",
               name, got_bits.size(), gv, exp_bits.size(), ev);
    end
    checks++;
    if (starts != 1 || stops != 1 || busy_bad != 0) begin
      errors++;
      $display("FAIL %s framing: starts=%0d stops=%0d busy_gaps=%0d, want 1 1 0",
               name, starts, stops, busy_bad);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) busy_bad++;
    end
    checks++;
    if (busy_bad != 0 || ack_err !== exp_err || SCL_O !== 1'b1 || SDA_O !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_after: extra_done/busy=%0d ack_err=%b scl=%b sda=%b, want 0 %b 1 1",
               name, busy_bad, ack_err, SCL_O, SDA_O, exp_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; SDA_I = 1'b1; rw = 1'b0; slave_addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (SCL_O !== 1'b1 || SDA_O !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
        ack_err !== 1'b0 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset: scl=%b sda=%b busy=%b done=%b err=%b rd=%h, want 1 1 0 0 0 00",
               SCL_O, SDA_O, busy, done, ack_err, rd_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_write_ack();
    run_frame("write_ack", 7'h79, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 0, 0);
  endtask

  task automatic test_read();
    run_frame("read", 7'h79, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C, 0, 0);
  endtask

  task automatic test_addr_nack();
    run_frame("addr_nack", 7'h22, 1'b0, 8'h5A, 1'b0, 1'b0, 8'h00, 0, 0);
  endtask

  task automatic test_write_nack();
    run_frame("write_nack", 7'h79, 1'b0, 8'hC3, 1'b1, 1'b0, 8'h00, 0, 0);
  endtask

  task automatic test_start_while_busy();
    run_frame("start_busy", 7'h51, 1'b0, 8'h96, 1'b1, 1'b1, 8'h00, 3 * BITP + 5, 0);
  endtask

  task automatic test_reset_mid_frame();
    run_frame("abort", 7'h79, 1'b0, 8'hF0, 1'b1, 1'b1, 8'h00, 0, 14 * BITP + 6);
    run_frame("after_abort", 7'h79, 1'b0, 8'h0F, 1'b1, 1'b1, 8'h00, 0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      logic [6:0] a;
      logic [7:0] d, r;
      logic       rwr, aa, da;
      a   = 7'($urandom);
      d   = 8'($urandom);
      r   = 8'($urandom);
      rwr = 1'($urandom);
      aa  = ($urandom_range(0, 4) != 0);
      da  = 1'($urandom);
      run_frame("random", a, rwr, d, aa, da, r, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_write_ack();
    test_read();
    test_addr_nack();
    test_write_nack();
    test_start_while_busy();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
